y86_instr_encoder: RTL and testbench

- Inverse of the fetch stage: accepts one decoded Y86-64 instruction (icode, ifunc, rA, rB, valC) over a valid/ready handshake.
- Serialises it into the byte-wide instruction memory in the exact layout fetch decodes, one byte per clock, little-endian valC.
- Used by the program loader and test infrastructure to build instruction-memory images from field-level descriptions instead of hand-coded bytes.

---
 rtl/y86_instr_encoder.sv | 181 ++++++++++++++++++
 tb/tb_y86_instr_encoder.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/y86_instr_encoder.sv
// Serialises one decoded Y86-64 instruction into byte-wide instruction memory, one byte per clock.
// Optional XOR checksum output csum_o is built when ENCODER_CHECKSUM_EN is defined.
module y86_instr_encoder #(
   parameter int ADDR_W    = 10,
   parameter int MEM_DEPTH = 1024
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic              base_load_i,
   input  logic [ADDR_W-1:0] base_addr_i,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   input  logic [3:0]        icode_i,
   input  logic [3:0]        ifunc_i,
   input  logic [3:0]        rA_i,
   input  logic [3:0]        rB_i,
   input  logic [63:0]       valC_i,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [7:0]        mem_wdata_o,
   output logic              done_o,
   output logic              err_o,
   output logic [ADDR_W-1:0] wptr_o
`ifdef ENCODER_CHECKSUM_EN
   ,
   output logic [7:0]        csum_o
`endif
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EMIT = 2'd1,
      S_ERR  = 2'd2
   } state_t;

   localparam logic [ADDR_W:0] LP_DEPTH = (ADDR_W+1)'(MEM_DEPTH);
   localparam logic [ADDR_W:0] LP_ONE   = (ADDR_W+1)'(1);

   state_t            r_state, w_nextState;
   logic [ADDR_W:0]   r_wptr, w_nextWptr;
   logic [71:0]       r_shift, w_nextShift;
   logic [3:0]        r_remain, w_nextRemain;
   logic              r_we, w_nextWe;
   logic [ADDR_W-1:0] r_addr, w_nextAddr;
   logic [7:0]        r_wdata, w_nextWdata;
   logic              r_done, w_nextDone;
   logic              r_err, w_nextErr;

   logic              w_needRegids;
   logic              w_needValc;
   logic [3:0]        w_len;
   logic [79:0]       w_bytes;
   logic [ADDR_W:0]   w_end;
   logic              w_reject;

   // Instruction length and byte image, byte 0 in the low bits.
   always_comb begin
      w_needRegids = 1'b0;
      w_needValc   = 1'b0;
      case (icode_i)
         4'h2, 4'h6, 4'hA, 4'hB: w_needRegids = 1'b1;
         4'h3, 4'h4, 4'h5: begin
            w_needRegids = 1'b1;
            w_needValc   = 1'b1;
         end
         4'h7, 4'h8: w_needValc = 1'b1;
         default: ;
      endcase
      w_len = 4'd1 + (w_needRegids ? 4'd1 : 4'd0) + (w_needValc ? 4'd8 : 4'd0);
      w_bytes       = '0;
      w_bytes[7:0]  = {icode_i, ifunc_i};
      if (w_needRegids) begin
         w_bytes[15:8] = {rA_i, rB_i};
         if (w_needValc)
            w_bytes[79:16] = valC_i;
      end else if (w_needValc) begin
         w_bytes[71:8] = valC_i;
      end
   end

   // Pointer is one bit wider than the address so a full memory never wraps back to 0.
   assign w_end      = r_wptr + {{(ADDR_W-3){1'b0}}, w_len};
   assign w_reject   = (icode_i >= 4'hC) || (w_end > LP_DEPTH);
   assign in_ready_o = rst_n_i && (r_state == S_IDLE) && !base_load_i;

   always_comb begin
      w_nextState  = r_state;
      w_nextWptr   = r_wptr;
      w_nextShift  = r_shift;
      w_nextRemain = r_remain;
      w_nextWe     = 1'b0;
      w_nextAddr   = r_addr;
      w_nextWdata  = r_wdata;
      w_nextDone   = 1'b0;
      w_nextErr    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (base_load_i) begin
               w_nextWptr = {1'b0, base_addr_i};
            end else if (in_valid_i) begin
               if (w_reject) begin
                  w_nextState = S_ERR;
                  w_nextErr   = 1'b1;
               end else begin
                  w_nextState  = S_EMIT;
                  w_nextWe     = 1'b1;
                  w_nextAddr   = r_wptr[ADDR_W-1:0];
                  w_nextWdata  = w_bytes[7:0];
                  w_nextWptr   = r_wptr + LP_ONE;
                  w_nextShift  = w_bytes[79:8];
                  w_nextRemain = w_len - 4'd1;
                  w_nextDone   = (w_len == 4'd1);
               end
            end
         end
         S_EMIT: begin
            if (r_remain != 4'd0) begin
               w_nextWe     = 1'b1;
               w_nextAddr   = r_wptr[ADDR_W-1:0];
               w_nextWdata  = r_shift[7:0];
               w_nextWptr   = r_wptr + LP_ONE;
               w_nextShift  = r_shift >> 8;
               w_nextRemain = r_remain - 4'd1;
               w_nextDone   = (r_remain == 4'd1);
            end else begin
               w_nextState = S_IDLE;
            end
         end
         S_ERR:   w_nextState = S_IDLE;
         default: w_nextState = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_state  <= S_IDLE;
         r_wptr   <= '0;
         r_shift  <= '0;
         r_remain <= '0;
         r_we     <= 1'b0;
         r_addr   <= '0;
         r_wdata  <= '0;
         r_done   <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         r_state  <= w_nextState;
         r_wptr   <= w_nextWptr;
         r_shift  <= w_nextShift;
         r_remain <= w_nextRemain;
         r_we     <= w_nextWe;
         r_addr   <= w_nextAddr;
         r_wdata  <= w_nextWdata;
         r_done   <= w_nextDone;
         r_err    <= w_nextErr;
      end
   end

   assign mem_we_o    = r_we;
   assign mem_addr_o  = r_addr;
   assign mem_wdata_o = r_wdata;
   assign done_o      = r_done;
   assign err_o       = r_err;
   assign wptr_o      = r_wptr[ADDR_W-1:0];

`ifdef ENCODER_CHECKSUM_EN
   logic [7:0] r_csum;

   // Folds in each byte the cycle after it is written; a pointer load starts a new image.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i)
         r_csum <= 8'h00;
      else if ((r_state == S_IDLE) && base_load_i)
         r_csum <= 8'h00;
      else if (r_we)
         r_csum <= r_csum ^ r_wdata;
   end

   assign csum_o = r_csum;
`endif

endmodule

// File: tb/tb_y86_instr_encoder.sv
// Self-checking bench for y86_instr_encoder: directed cases plus randomized instructions
// scored against a byte-list model of the Y86-64 encoding rules.
module tb_y86_instr_encoder;

   localparam int ADDR_W    = 10;
   localparam int MEM_DEPTH = 1024;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              base_load = 1'b0;
   logic [ADDR_W-1:0] base_addr = '0;
   logic              in_valid = 1'b0;
   logic              in_ready_o;
   logic [3:0]        icode = '0, ifunc = '0, rA = '0, rB = '0;
   logic [63:0]       valC = '0;
   logic              mem_we_o;
   logic [ADDR_W-1:0] mem_addr_o;
   logic [7:0]        mem_wdata_o;
   logic              done_o;
   logic              err_o;
   logic [ADDR_W-1:0] wptr_o;
`ifdef ENCODER_CHECKSUM_EN
   logic [7:0]        csum_o;
`endif

   y86_instr_encoder #(.ADDR_W(ADDR_W), .MEM_DEPTH(MEM_DEPTH)) dut (
      .clk_i(clk),
      .rst_n_i(rst_n),
      .base_load_i(base_load),
      .base_addr_i(base_addr),
      .in_valid_i(in_valid),
      .in_ready_o(in_ready_o),
      .icode_i(icode),
      .ifunc_i(ifunc),
      .rA_i(rA),
      .rB_i(rB),
      .valC_i(valC),
      .mem_we_o(mem_we_o),
      .mem_addr_o(mem_addr_o),
      .mem_wdata_o(mem_wdata_o),
      .done_o(done_o),
      .err_o(err_o),
      .wptr_o(wptr_o)
`ifdef ENCODER_CHECKSUM_EN
      , .csum_o(csum_o)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [ADDR_W-1:0] addr;
      logic [7:0]        data;
      logic              done;
   } wr_t;

   int          compared   = 0;
   int          mismatched = 0;
   wr_t         expQ[$];
   int          errPending = 0;
   logic [10:0] wptrM      = '0;
   logic [7:0]  csumM      = 8'h00;
   logic [7:0]  tbMem[MEM_DEPTH];

   task automatic checkOutput(input string name, input logic [79:0] act, input logic [79:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Encoding rules expressed as a byte list: opcode byte, optional register byte, optional little-endian constant.
   function automatic void encode(input logic [3:0] ic, input logic [3:0] ifn, input logic [3:0] ra,
                                  input logic [3:0] rb, input logic [63:0] vc,
                                  output int len, output logic [79:0] bytesOut);
      bit regs, cons;
      int k;
      regs = (ic inside {4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB});
      cons = (ic inside {4'h3, 4'h4, 4'h5, 4'h7, 4'h8});
      len = 1 + (regs ? 1 : 0) + (cons ? 8 : 0);
      bytesOut = '0;
      bytesOut[7:0] = {ic, ifn};
      k = 1;
      if (regs) begin
         bytesOut[15:8] = {ra, rb};
         k = 2;
      end
      if (cons)
         for (int i = 0; i < 8; i++)
            bytesOut[8*(k+i) +: 8] = vc[8*i +: 8];
   endfunction

   // Scoreboard: every write must match the head of the expected byte queue; strobes must not appear unannounced.
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         if (mem_we_o) begin
            tbMem[mem_addr_o] = mem_wdata_o;
            if (expQ.size() == 0) begin
               checkOutput("unexpected write addr", {1'b1, mem_addr_o}, {1'b0, mem_addr_o});
            end else begin
               wr_t e;
               e = expQ.pop_front();
               checkOutput("write addr/data/done", {mem_addr_o, mem_wdata_o, done_o}, {e.addr, e.data, e.done});
            end
         end else if (done_o) begin
            checkOutput("done without write", done_o, 1'b0);
         end
         if (err_o) begin
            if (errPending > 0) begin
               errPending--;
               checkOutput("err with write strobe", mem_we_o, 1'b0);
            end else begin
               checkOutput("unexpected err", err_o, 1'b0);
            end
         end
      end
   end

   task automatic loadBase(input logic [ADDR_W-1:0] a);
      base_load = 1'b1;
      base_addr = a;
      in_valid  = 1'($urandom_range(0, 1));
      #1;
      checkOutput("ready low during base_load", in_ready_o, 1'b0);
      @(negedge clk);
      base_load = 1'b0;
      in_valid  = 1'b0;
      wptrM     = {1'b0, a};
      csumM     = 8'h00;
      checkOutput("wptr after base_load", wptr_o, a);
`ifdef ENCODER_CHECKSUM_EN
      checkOutput("csum cleared by base_load", csum_o, 8'h00);
`endif
   endtask

   // One instruction: present it for one cycle, predict its bytes, then time the return to ready.
   task automatic applyStimulus(input logic [3:0] ic, input logic [3:0] ifn, input logic [3:0] ra,
                                input logic [3:0] rb, input logic [63:0] vc, input bit noise);
      int          len, c, expLat;
      logic [79:0] b;
      bit          bad;
      for (int i = 0; i < 20 && !in_ready_o; i++) @(negedge clk);
      checkOutput("ready before accept", in_ready_o, 1'b1);
      icode = ic; ifunc = ifn; rA = ra; rB = rb; valC = vc;
      in_valid = 1'b1;
      encode(ic, ifn, ra, rb, vc, len, b);
      bad = (ic >= 4'hC) || (int'(wptrM) + len > MEM_DEPTH);
      if (bad) begin
         errPending++;
         expLat = 2;
      end else begin
         for (int k = 0; k < len; k++) begin
            wr_t e;
            e.addr = ADDR_W'(int'(wptrM) + k);
            e.data = b[8*k +: 8];
            e.done = (k == len - 1);
            expQ.push_back(e);
            csumM ^= b[8*k +: 8];
         end
         wptrM += 11'(len);
         expLat = len + 1;
      end
      @(posedge clk);
      #1 in_valid = 1'b0;
      @(negedge clk);
      if (bad) checkOutput("err one cycle after accept", {err_o, mem_we_o}, 2'b10);
      c = 1;
      while (!in_ready_o && c < 20) begin
         if (noise && c < expLat) begin
            base_load = 1'($urandom_range(0, 1));
            base_addr = ADDR_W'($urandom);
            in_valid  = 1'($urandom_range(0, 1));
            icode     = 4'($urandom);
            @(posedge clk);
            #1;
            base_load = 1'b0;
            in_valid  = 1'b0;
         end
         @(negedge clk);
         c++;
      end
      checkOutput("ready latency", c, expLat);
      checkOutput("wptr after instruction", wptr_o, wptrM[ADDR_W-1:0]);
      checkOutput("all bytes written", expQ.size(), 0);
      checkOutput("err reported", errPending, 0);
`ifdef ENCODER_CHECKSUM_EN
      checkOutput("csum", csum_o, csumM);
`endif
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int          len;
      logic [79:0] b;
      logic [7:0]  seqBytes[13];

      for (int i = 0; i < MEM_DEPTH; i++) tbMem[i] = 8'hxx;

      // Reset values, including in_ready held low while in reset.
      in_valid = 1'b1;
      #12;
      checkOutput("reset outputs", {mem_we_o, mem_addr_o, mem_wdata_o, done_o, err_o, wptr_o, in_ready_o},
                  {1'b0, 10'd0, 8'd0, 1'b0, 1'b0, 10'd0, 1'b0});
      in_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      #1 checkOutput("ready after reset release", in_ready_o, 1'b1);
      @(negedge clk);

      // Pin the model itself with a hand-encoded irmovq.
      encode(4'h3, 4'h0, 4'hF, 4'h2, 64'h10, len, b);
      checkOutput("model irmovq len", len, 10);
      checkOutput("model irmovq bytes", b, 80'h0000000000000010F230);

      loadBase(10'd10);
      applyStimulus(4'h3, 4'h0, 4'hF, 4'h2, 64'h10, 1'b0);
      checkOutput("irmovq image", {tbMem[10], tbMem[11], tbMem[12], tbMem[19]}, 32'h30F21000);
      checkOutput("irmovq final wptr", wptr_o, 10'd20);
`ifdef ENCODER_CHECKSUM_EN
      checkOutput("irmovq csum", csum_o, 8'hD2);
`endif

      loadBase(10'd0);
      applyStimulus(4'h0, 4'h0, 4'h5, 4'h5, 64'hFFFF, 1'b0);
      applyStimulus(4'h1, 4'h0, 4'h0, 4'h0, 64'h0, 1'b0);
      applyStimulus(4'h6, 4'h0, 4'h0, 4'h3, 64'h1234, 1'b0);
      applyStimulus(4'h7, 4'h0, 4'h9, 4'h9, 64'h27, 1'b0);
      seqBytes = '{8'h00, 8'h10, 8'h60, 8'h03, 8'h70, 8'h27, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      for (int i = 0; i < 13; i++) checkOutput($sformatf("sequence byte %0d", i), tbMem[i], seqBytes[i]);
      checkOutput("sequence wptr", wptr_o, 10'd13);

      applyStimulus(4'hC, 4'h0, 4'h0, 4'h0, 64'h0, 1'b0);
      applyStimulus(4'hF, 4'h0, 4'h0, 4'h0, 64'h0, 1'b0);
      checkOutput("wptr after rejects", wptr_o, 10'd13);

      loadBase(10'd1015);
      applyStimulus(4'h3, 4'h0, 4'hF, 4'h2, 64'h10, 1'b0);
      loadBase(10'd1014);
      applyStimulus(4'h3, 4'h0, 4'hF, 4'h2, 64'h10, 1'b0);
      checkOutput("last bytes", {tbMem[1014], tbMem[1023]}, 16'h3000);
      checkOutput("full memory wptr", wptr_o, 10'd0);
      applyStimulus(4'h0, 4'h0, 4'h0, 4'h0, 64'h0, 1'b0);
      checkOutput("wptr after full reject", wptr_o, 10'd0);

      // Reset in the middle of a call: three bytes land, the rest never do.
      loadBase(10'd100);
      icode = 4'h8; ifunc = 4'h0; valC = 64'h0123456789ABCDEF;
      in_valid = 1'b1;
      encode(4'h8, 4'h0, 4'h0, 4'h0, 64'h0123456789ABCDEF, len, b);
      for (int k = 0; k < len; k++) begin
         wr_t e;
         e.addr = ADDR_W'(100 + k);
         e.data = b[8*k +: 8];
         e.done = (k == len - 1);
         expQ.push_back(e);
      end
      @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("outputs in mid-emit reset", {mem_we_o, mem_addr_o, mem_wdata_o, done_o, err_o, wptr_o, in_ready_o},
                  {1'b0, 10'd0, 8'd0, 1'b0, 1'b0, 10'd0, 1'b0});
      expQ.delete();
      wptrM = '0;
      csumM = 8'h00;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      checkOutput("bytes before reset", {tbMem[100], tbMem[101], tbMem[102]}, 24'h80EFCD);
      checkOutput("byte after reset not written", tbMem[103], 8'hxx);
      checkOutput("wptr after mid-emit reset", wptr_o, 10'd0);

      // Randomized instructions with occasional pointer loads near the top of memory.
      for (int n = 0; n < 300; n++) begin
         logic [3:0] ic;
         if ($urandom_range(0, 7) == 0) begin
            if ($urandom_range(0, 1) == 1) loadBase(ADDR_W'($urandom_range(990, 1023)));
            else                           loadBase(ADDR_W'($urandom_range(0, 1023)));
         end
         ic = ($urandom_range(0, 9) < 8) ? 4'($urandom_range(0, 11)) : 4'($urandom);
         applyStimulus(ic, 4'($urandom), 4'($urandom), 4'($urandom), {$urandom, $urandom},
                       1'($urandom_range(0, 1)));
      end

      repeat (3) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
